// File: rtl/axi_stream_slave_endpoint.sv
// axi_stream_slave_endpoint: AXI-Stream sink with random backpressure, statistics and protocol checks
module axi_stream_slave_endpoint #(
    parameter int          byte_width  = 4,
    parameter int          id_width    = 1,
    parameter int          dest_width  = 1,
    parameter int          user_width  = 1,
    parameter int          count_width = 32,
    parameter logic [15:0] lfsr_seed   = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tvalid,
    output logic                    tready,
    input  logic [8*byte_width-1:0] tdata,
    input  logic [byte_width-1:0]   tstrb,
    input  logic [byte_width-1:0]   tkeep,
    input  logic                    tlast,
    input  logic [id_width-1:0]     tid,
    input  logic [dest_width-1:0]   tdest,
    input  logic [user_width-1:0]   tuser,
    input  logic                    stall_en,
    input  logic                    clear,
    output logic [count_width-1:0]  beat_count,
    output logic [count_width-1:0]  packet_count,
    output logic [count_width-1:0]  byte_count,
    output logic                    in_packet,
    output logic                    cap_valid,
    output logic [8*byte_width-1:0] cap_data,
    output logic                    cap_last,
    output logic                    err_unstable,
    output logic                    err_strb,
    output logic                    err_route,
    output logic                    err_any
);
    logic [15:0]                lfsr;
    logic [15:0]                lfsr_next;
    logic                       xfer;
    logic [count_width:0]       nbytes;
    logic [count_width:0]       byte_sum;
    logic                       unstable;
    logic                       stalled;
    logic [8*byte_width-1:0]    s_data;
    logic [byte_width-1:0]      s_strb;
    logic [byte_width-1:0]      s_keep;
    logic                       s_last;
    logic [id_width-1:0]        s_id;
    logic [dest_width-1:0]      s_dest;
    logic [user_width-1:0]      s_user;
    logic [id_width-1:0]        r_id;
    logic [dest_width-1:0]      r_dest;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign xfer      = tvalid && tready;
    assign byte_sum  = {1'b0, byte_count} + nbytes;
    assign err_any   = err_unstable | err_strb | err_route;

    // data bytes in this beat, and whether a stalled beat changed its held content
    always_comb begin
        nbytes   = '0;
        unstable = !tvalid || tstrb != s_strb || tkeep != s_keep || tlast != s_last ||
                   tid != s_id || tdest != s_dest || tuser != s_user;
        for (int i = 0; i < byte_width; i++) begin
            nbytes = nbytes + (count_width+1)'(tkeep[i] & tstrb[i]);
            if (s_keep[i] && s_strb[i] && tdata[8*i +: 8] != s_data[8*i +: 8])
                unstable = 1'b1;
        end
    end

    // backpressure generator; free-running, untouched by clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr   <= lfsr_seed;
            tready <= 1'b0;
        end else begin
            lfsr   <= lfsr_next;
            tready <= !stall_en || lfsr_next[0];
        end
    end

    // capture of the most recently accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_last  <= 1'b0;
        end else begin
            cap_valid <= xfer;
            if (xfer) begin
                cap_data <= tdata;
                cap_last <= tlast;
            end
        end
    end

    // statistics, packet tracking and sticky protocol checks; clear wins over everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count   <= '0;
            packet_count <= '0;
            byte_count   <= '0;
            in_packet    <= 1'b0;
            err_unstable <= 1'b0;
            err_strb     <= 1'b0;
            err_route    <= 1'b0;
            stalled      <= 1'b0;
            s_data       <= '0;
            s_strb       <= '0;
            s_keep       <= '0;
            s_last       <= 1'b0;
            s_id         <= '0;
            s_dest       <= '0;
            s_user       <= '0;
            r_id         <= '0;
            r_dest       <= '0;
        end else if (clear) begin
            beat_count   <= '0;
            packet_count <= '0;
            byte_count   <= '0;
            in_packet    <= 1'b0;
            err_unstable <= 1'b0;
            err_strb     <= 1'b0;
            err_route    <= 1'b0;
            stalled      <= 1'b0;
            r_id         <= '0;
            r_dest       <= '0;
        end else begin
            stalled <= tvalid && !tready;
            s_data  <= tdata;
            s_strb  <= tstrb;
            s_keep  <= tkeep;
            s_last  <= tlast;
            s_id    <= tid;
            s_dest  <= tdest;
            s_user  <= tuser;
            if (stalled && unstable)
                err_unstable <= 1'b1;
            if (tvalid && |(tstrb & ~tkeep))
                err_strb <= 1'b1;
            if (xfer) begin
                if (beat_count != '1)
                    beat_count <= beat_count + count_width'(1);
                if (tlast && packet_count != '1)
                    packet_count <= packet_count + count_width'(1);
                byte_count <= byte_sum[count_width] ? '1 : byte_sum[count_width-1:0];
                in_packet  <= !tlast;
                if (!in_packet) begin
                    r_id   <= tid;
                    r_dest <= tdest;
                end else if (tid != r_id || tdest != r_dest) begin
                    err_route <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_slave_endpoint.sv
// tb_axi_stream_slave_endpoint: directed checks of counting, capture, error flags, clear and reset
module tb_axi_stream_slave_endpoint;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic [3:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic [0:0]  tid = '0;
    logic [0:0]  tdest = '0;
    logic [0:0]  tuser = '0;
    logic        stall_en = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  beat_count, packet_count, byte_count;
    logic        in_packet, cap_valid, cap_last;
    logic [31:0] cap_data;
    logic        err_unstable, err_strb, err_route, err_any;
    int          total = 0;
    int          bad = 0;

    axi_stream_slave_endpoint #(.count_width(4)) dut (
        .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest), .tuser(tuser),
        .stall_en(stall_en), .clear(clear), .beat_count(beat_count), .packet_count(packet_count),
        .byte_count(byte_count), .in_packet(in_packet), .cap_valid(cap_valid), .cap_data(cap_data),
        .cap_last(cap_last), .err_unstable(err_unstable), .err_strb(err_strb),
        .err_route(err_route), .err_any(err_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                         input logic l, input logic i);
        tdata = d;
        tkeep = k;
        tstrb = s;
        tlast = l;
        tid   = i;
        tvalid = 1'b1;
    endtask

    task automatic finish_beat();
        logic hs;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            hs = tready;
            tick();
            n++;
        end
        tvalid = 1'b0;
        chk("accept", {31'b0, hs}, 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                        input logic l, input logic i);
        drive(d, k, s, l, i);
        finish_beat();
    endtask

    task automatic stall_send(input logic [3:0] s);
        int n;
        n = 0;
        while (tready && n < 200) begin
            tick();
            n++;
        end
        chk("stall_seen", {31'b0, tready}, 32'd0);
        drive(32'h1234_5678, 4'hF, s, 1'b1, 1'b0);
        tick();
        tdata[7:0] = ~tdata[7:0];
        finish_beat();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_tready", {31'b0, tready}, 32'd0);
        chk("rst_beats", {28'b0, beat_count}, 32'd0);
        chk("rst_err", {31'b0, err_any}, 32'd0);
        chk("rst_cap_valid", {31'b0, cap_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("ready_after_rst", {31'b0, tready}, 32'd1);

        send(32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 1'b0);
        chk("t1_beats", {28'b0, beat_count}, 32'd1);
        chk("t1_packets", {28'b0, packet_count}, 32'd1);
        chk("t1_bytes", {28'b0, byte_count}, 32'd4);
        chk("t1_cap_data", cap_data, 32'hDEADBEEF);
        chk("t1_cap_valid", {31'b0, cap_valid}, 32'd1);
        chk("t1_cap_last", {31'b0, cap_last}, 32'd1);
        chk("t1_err", {31'b0, err_any}, 32'd0);
        tick();
        chk("t1_cap_pulse_end", {31'b0, cap_valid}, 32'd0);

        pulse_clear();
        send(32'h0000_0001, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t2_inpkt1", {31'b0, in_packet}, 32'd1);
        send(32'h0000_0002, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t2_inpkt2", {31'b0, in_packet}, 32'd1);
        send(32'h0000_0003, 4'h3, 4'h1, 1'b1, 1'b0);
        chk("t2_inpkt3", {31'b0, in_packet}, 32'd0);
        chk("t2_bytes", {28'b0, byte_count}, 32'd9);
        chk("t2_packets", {28'b0, packet_count}, 32'd1);
        chk("t2_beats", {28'b0, beat_count}, 32'd3);

        stall_en = 1'b1;
        pulse_clear();
        for (int n = 0; n < 6; n++) send(32'hA5A5_0000 + n, 4'hF, 4'hF, 1'b1, 1'b0);
        chk("t3_hold_ok", {31'b0, err_unstable}, 32'd0);
        stall_send(4'hF);
        chk("t3_unstable", {31'b0, err_unstable}, 32'd1);
        chk("t3_err_any", {31'b0, err_any}, 32'd1);
        pulse_clear();
        stall_send(4'hE);
        chk("t3_null_byte_ok", {31'b0, err_unstable}, 32'd0);

        stall_en = 1'b0;
        pulse_clear();
        tick();
        drive(32'h0, 4'h3, 4'h4, 1'b1, 1'b0);
        tick();
        tvalid = 1'b0;
        chk("t4_strb", {31'b0, err_strb}, 32'd1);
        chk("t4_strb_any", {31'b0, err_any}, 32'd1);
        tick();
        chk("t4_strb_held", {31'b0, err_strb}, 32'd1);
        pulse_clear();
        chk("t4_clr_strb", {31'b0, err_strb}, 32'd0);
        chk("t4_clr_any", {31'b0, err_any}, 32'd0);
        chk("t4_clr_beats", {28'b0, beat_count}, 32'd0);
        chk("t4_clr_bytes", {28'b0, byte_count}, 32'd0);
        chk("t4_clr_packets", {28'b0, packet_count}, 32'd0);

        send(32'h11, 4'hF, 4'hF, 1'b0, 1'b0);
        send(32'h22, 4'hF, 4'hF, 1'b1, 1'b1);
        chk("t5_route", {31'b0, err_route}, 32'd1);
        pulse_clear();
        send(32'h33, 4'hF, 4'hF, 1'b1, 1'b0);
        send(32'h44, 4'hF, 4'hF, 1'b1, 1'b1);
        chk("t5_route_boundary", {31'b0, err_route}, 32'd0);

        pulse_clear();
        for (int n = 0; n < 17; n++) send(32'h100 + n, 4'hF, 4'hF, 1'b1, 1'b0);
        chk("t6_beats_sat", {28'b0, beat_count}, 32'hF);
        chk("t6_packets_sat", {28'b0, packet_count}, 32'hF);
        chk("t6_bytes_sat", {28'b0, byte_count}, 32'hF);
        send(32'h200, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t6_inpkt", {31'b0, in_packet}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_tready", {31'b0, tready}, 32'd0);
        chk("t6_rst_beats", {28'b0, beat_count}, 32'd0);
        chk("t6_rst_packets", {28'b0, packet_count}, 32'd0);
        chk("t6_rst_inpkt", {31'b0, in_packet}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_stream_slave_endpoint.md
Name: axi_stream_slave_endpoint

Overview:
Synthesizable AXI-Stream receiver (slave) endpoint used as the sink side of stream benches and as a hardware protocol checker. Drives TREADY, optionally with pseudo-random backpressure, and consumes every beat. Counts beats, packets and data bytes. Flags violations of transmitter rules as sticky error bits: handshake stability, TKEEP/TSTRB legality, and routing consistency within a packet.

Parameters:
byte_width, 4, TDATA width in bytes (TDATA = 8*byte_width bits)
id_width, 1, TID width (>=1)
dest_width, 1, TDEST width (>=1)
user_width, 1, TUSER width (>=1)
count_width, 32, width of each statistics counter
lfsr_seed, 16'hACE1, backpressure LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
tvalid  in  1  transmitter valid
tready  out  1  endpoint ready (registered)
tdata  in  8*byte_width  payload
tstrb  in  byte_width  byte qualifier: data byte
tkeep  in  byte_width  byte qualifier: data or position byte
tlast  in  1  packet boundary
tid  in  id_width  stream ID
tdest  in  dest_width  routing
tuser  in  user_width  sideband
stall_en  in  1  1 = random backpressure, 0 = always ready
clear  in  1  synchronous clear of counters, flags and packet state
beat_count  out  count_width  accepted transfers
packet_count  out  count_width  accepted transfers with tlast
byte_count  out  count_width  accepted data bytes
in_packet  out  1  mid-packet (last transfer had tlast=0)
cap_valid  out  1  one-cycle pulse: a transfer was accepted on the previous edge
cap_data  out  8*byte_width  tdata of last accepted beat
cap_last  out  1  tlast of last accepted beat
err_unstable  out  1  sticky: tvalid dropped or payload changed while stalled
err_strb  out  1  sticky: tstrb set on a byte with tkeep clear
err_route  out  1  sticky: tid/tdest changed inside a packet
err_any  out  1  OR of the err_* flags (combinational)

Behaviour:
- Reset (async assert, released on clock): tready=0; all counters 0; in_packet, cap_valid, cap_data, cap_last and all err_* = 0; LFSR = lfsr_seed.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset. clear does not affect it.
- tready <= !stall_en || lfsr_next[0]. First edge after reset release sets tready=1 when stall_en=0.
- Transfer: tvalid && tready at a rising edge.
- Per transfer:
  - beat_count += 1
  - packet_count += tlast
  - byte_count += popcount(tkeep & tstrb). Position bytes and null bytes are not counted.
  - All counters saturate at all-ones and do not wrap.
  - cap_valid=1 on the next cycle; cap_data/cap_last updated. cap_valid=0 in all other cycles.
- in_packet: set by a transfer with tlast=0; cleared by a transfer with tlast=1. The first beat of a packet (in_packet=0) latches tid/tdest as the packet route.
- err_route: set by a transfer with in_packet=1 whose tid or tdest differs from the latched route.
- Stall check:
  - Register stalled = tvalid && !tready each edge, snapshotting the full payload.
  - In the following cycle, if stalled was 1:
    - tvalid=0 sets err_unstable.
    - Any change in tstrb, tkeep, tlast, tid, tdest or tuser sets err_unstable.
    - Any change in a tdata byte i with snapshot tkeep[i]&tstrb[i]=1 sets err_unstable. Changes on other bytes are ignored.
  - Check evaluated at the next edge.
- err_strb: set at an edge where tvalid && |(tstrb & ~tkeep). Checked regardless of tready.
- Error flags hold until reset or clear.
- clear: zeroes counters, err_*, in_packet, the stalled flag and the latched route. It has priority over same-edge updates: a transfer on a clear edge is accepted (handshake completes) but not counted or checked. cap_* are unaffected.
- Reset mid-packet: tready drops immediately; all state cleared; the partial packet is forgotten.

Test Plan:
- Reset, stall_en=0, one beat tdata=32'hDEADBEEF, tkeep=tstrb=4'hF, tlast=1 -> beat_count=1, packet_count=1, byte_count=4, cap_data=32'hDEADBEEF, cap_valid 1-cycle pulse, err_any=0.
- 3-beat packet, final beat tkeep=4'h3 tstrb=4'h1 -> byte_count=9, packet_count=1, in_packet=1 after beats 1–2 and 0 after beat 3.
- stall_en=1, transmitter holds all signals while tready=0 -> no errors. Repeat, changing tdata[7:0] mid-stall with tstrb[0]=1 -> err_unstable=1. Repeat with tstrb[0]=0 and tkeep[0]=1 -> err_unstable=0.
- tvalid=1, tkeep=4'h3, tstrb=4'h4 -> err_strb=1 after the edge and held; pulse clear -> all flags and counters 0.
- Beat 1 tid=0 tlast=0, beat 2 tid=1 -> err_route=1. Same tid change across a tlast boundary -> err_route=0.
- count_width=4, 17 single-beat packets -> beat_count=packet_count=4'hF. Assert reset mid-packet -> tready=0 before next edge, counters 0, in_packet=0.
